// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: turns EX/MEM loads and stores into one
// mem_req/mem_ack bus transaction, aligns load data and stalls the pipeline meanwhile.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  size_in,
  input  logic        sign_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        flush_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        mem_flush,
  output logic        misalign,
  output logic        bus_error,
  output logic [1:0]  state_dbg
);

  // Bus handshake: mem_req acts as valid and stays high, with mem_we/addr/be/wdata
  // stable, until the cycle mem_ack (ready/completion) is sampled high or the
  // timeout fires; mem_rdata is only looked at in the mem_ack cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic        flush_seen;
  logic        is_load_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        access;
  logic        bad;
  logic        timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] shifted;
  logic [31:0] aligned;

  assign state_dbg   = state;
  assign access      = (mem_read_in | mem_write_in) & ~flush_in;
  assign bad         = (size_in[1] & (addr_in[1:0] != 2'b00)) |
                       ((size_in == 2'b01) & addr_in[0]);
  assign timeout_hit = (cnt == TIMEOUT_M1);

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata_in;
    case (size_in)
      2'b00: begin
        be_calc    = 4'b0001 << addr_in[1:0];
        wdata_calc = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {addr_in[1], 1'b0};
        wdata_calc = {2{wdata_in[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_in;
      end
    endcase
  end

  // Alignment uses the offset/size captured at issue, not the live EX/MEM inputs.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    aligned = shifted;
    case (size_q)
      2'b00:   aligned = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   aligned = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_flush  = 1'b0;
    case (state)
      S_IDLE: begin
        mem_flush = flush_in | access;
        stall     = access & ~bad;
        if (access & ~bad) state_next = S_WAIT;
      end
      S_WAIT: begin
        stall     = 1'b1;
        mem_flush = 1'b1;
        if (mem_ack | timeout_hit) state_next = S_DONE;
      end
      S_DONE: begin
        mem_flush  = flush_seen | bus_error;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      flush_seen <= 1'b0;
      is_load_q  <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      load_data  <= 32'd0;
      misalign   <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state     <= state_next;
      misalign  <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access && bad) begin
            misalign <= 1'b1;
          end else if (access) begin
            mem_req    <= 1'b1;
            mem_we     <= mem_write_in;
            mem_addr   <= {addr_in[31:2], 2'b00};
            mem_be     <= be_calc;
            mem_wdata  <= wdata_calc;
            cnt        <= 8'd0;
            flush_seen <= 1'b0;
            is_load_q  <= ~mem_write_in;
            sign_q     <= sign_in;
            size_q     <= size_in;
            off_q      <= addr_in[1:0];
          end
        end
        S_WAIT: begin
          // A squash during WAIT only turns the result into a bubble later.
          if (flush_in) flush_seen <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_load_q) load_data <= aligned;
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            load_data <= 32'd0;
            bus_error <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random load/store transactions against a simple behavioural model
// of the MEM-stage controller, with a responder playing the data memory.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [1:0]  size_in = 2'b00;
  logic        sign_in = 1'b0;
  logic [31:0] addr_in = 32'd0;
  logic [31:0] wdata_in = 32'd0;
  logic        flush_in = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req, mem_we, stall, mem_flush, misalign, bus_error;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_load = 32'd0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .size_in(size_in), .sign_in(sign_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .flush_in(flush_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .load_data(load_data), .stall(stall), .mem_flush(mem_flush),
    .misalign(misalign), .bus_error(bus_error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    flush_in     = 1'b0;
  endtask

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 32'd1 << (a % 4);
    if (sz == 2'd1) return 32'd3 << (a % 4);
    return 32'd15;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [1:0] sz, input logic sg,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Entered and left at posedge+1 of an IDLE cycle. ack_cyc=0 means never ack;
  // flush_cyc=0 means no flush, otherwise the WAIT cycle that sees flush_in.
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int ack_cyc, input int flush_cyc);
    int wait_len;
    logic berr;
    mem_read_in = rd; mem_write_in = wr; size_in = sz; sign_in = sg;
    addr_in = addr; wdata_in = wd; flush_in = 1'b0;
    @(negedge clk);
    chk("issue_flush", mem_flush, 1);
    chk("issue_req", mem_req, 0);
    if (is_bad(sz, addr)) begin
      chk("mis_stall", stall, 0);
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      chk("mis_pulse", misalign, 1);
      chk("mis_req", mem_req, 0);
      chk("mis_stall2", stall, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_end", misalign, 0);
      @(posedge clk); #1;
      return;
    end
    chk("issue_stall", stall, 1);
    berr = (ack_cyc == 0);
    wait_len = berr ? TO : ack_cyc;
    if (berr) exp_q.push_back(32'd0);
    else if (rd && !wr) exp_q.push_back(exp_ld(sz, sg, addr, rdata));
    else exp_q.push_back(exp_load);
    for (int c = 1; c <= wait_len; c++) begin
      @(posedge clk); #1;
      mem_ack   = (c == ack_cyc);
      mem_rdata = mem_ack ? rdata : $urandom;
      flush_in  = (c == flush_cyc);
      @(negedge clk);
      chk("wait_req", mem_req, 1);
      chk("wait_stall", stall, 1);
      chk("wait_flush", mem_flush, 1);
      if (c == 1) begin
        chk("bus_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("bus_be", mem_be, exp_be(sz, addr));
        chk("bus_we", mem_we, wr);
        if (wr) chk("bus_wdata", mem_wdata, exp_wd(sz, wd));
      end
    end
    // DONE cycle: a stray ack here must be ignored
    @(posedge clk); #1;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom; flush_in = 1'b0;
    @(negedge clk);
    exp_load = exp_q.pop_front();
    chk("done_stall", stall, 0);
    chk("done_req", mem_req, 0);
    chk("done_berr", bus_error, berr);
    chk("done_flush", mem_flush, berr || (flush_cyc >= 1 && flush_cyc <= wait_len));
    chk("done_load", load_data, exp_load);
    @(posedge clk); #1;
    idle_inputs();
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("post_load", load_data, exp_load);
    chk("post_req", mem_req, 0);
    chk("post_stall", stall, 0);
    chk("post_flush", mem_flush, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    // clock/reset
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_load", load_data, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;

    // directed
    run_txn(1, 0, 2'd2, 0, 32'h100, 32'd0, 32'hDEADBEEF, 2, 0);
    run_txn(1, 0, 2'd0, 1, 32'h103, 32'd0, 32'h80FF_0000, 1, 0);
    run_txn(1, 0, 2'd0, 0, 32'h103, 32'd0, 32'h80FF_0000, 3, 0);
    run_txn(0, 1, 2'd1, 0, 32'h206, 32'h0000_1234, 32'd0, 1, 0);
    run_txn(1, 1, 2'd0, 0, 32'h305, 32'hA5A5_A5C3, 32'd0, 2, 0);
    run_txn(1, 0, 2'd2, 0, 32'h101, 32'd0, 32'd0, 1, 0);
    run_txn(1, 0, 2'd1, 1, 32'h402, 32'd0, 32'h8001_7FFF, 0, 0);
    run_txn(1, 0, 2'd1, 1, 32'h402, 32'd0, 32'h8001_7FFF, 2, 1);
    run_txn(1, 0, 2'd3, 0, 32'h500, 32'd0, 32'h1234_5678, 4, 3);

    // squash in IDLE: no request, bubble only
    mem_read_in = 1'b1; size_in = 2'd2; addr_in = 32'h600; flush_in = 1'b1;
    @(negedge clk);
    chk("sq_stall", stall, 0);
    chk("sq_flush", mem_flush, 1);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    chk("sq_req", mem_req, 0);
    chk("sq_mis", misalign, 0);
    @(posedge clk); #1;

    // reset while waiting for ack, then a late ack
    mem_read_in = 1'b1; size_in = 2'd2; addr_in = 32'h700;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_req", mem_req, 1);
    #2; idle_inputs(); reset = 1'b0;
    #1;
    chk("rw_req0", mem_req, 0);
    chk("rw_addr0", mem_addr, 0);
    chk("rw_be0", mem_be, 0);
    chk("rw_load0", load_data, 0);
    chk("rw_stall0", stall, 0);
    chk("rw_flush0", mem_flush, 0);
    exp_load = 32'd0;
    @(posedge clk); #1; reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_stall", stall, 0);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_load", load_data, 0);
    @(posedge clk); #1;

    // random
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [1:0] sz;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
        else if (sz >= 2'd2) a = a & 32'hFFFF_FFFC;
      end
      run_txn(kind != 1, kind != 0, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
              $urandom_range(0, TO), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store controller. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Converts each load/store into a handshaked data-memory bus transaction and aligns load data.
- Stalls the upstream pipeline while the transaction is outstanding.
- Drives the MEM/WB register's data input and mem_flush (bubble/squash) input.

Parameters:
- TIMEOUT, 16: cycles to wait for mem_ack before a bus error is declared (legal range 1..255; 8-bit counter).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read_in  input  1  EX/MEM: instruction is a load.
- mem_write_in  input  1  EX/MEM: instruction is a store.
- size_in  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- sign_in  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- addr_in  input  32  byte address (ALU result).
- wdata_in  input  32  store data (rt value).
- flush_in  input  1  squash the instruction currently in MEM.
- mem_req  output  1  bus request, held until ack.
- mem_we  output  1  1 = write.
- mem_addr  output  32  word address {addr_in[31:2],2'b00}.
- mem_be  output  4  byte enables, little-endian lanes.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  one-cycle completion strobe from memory.
- mem_rdata  input  32  read word, valid with mem_ack.
- load_data  output  32  aligned/extended load result, to MEM/WB data_in.
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- mem_flush  output  1  insert bubble in MEM/WB.
- misalign  output  1  one-cycle misaligned-access pulse.
- bus_error  output  1  one-cycle timeout pulse.

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0. All registered outputs 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data, misalign, bus_error. Reset mid-transaction abandons it: mem_req drops immediately and no late ack is honoured.
- Definitions:
  - access = (mem_read_in|mem_write_in) & ~flush_in.
  - bad = word access with addr_in[1:0]!=0, or half access with addr_in[0]!=0.
  - If mem_read_in and mem_write_in are both 1, the access is treated as a store.
- IDLE:
  - No access: stall=0, mem_flush=flush_in.
  - access & bad: no request. misalign pulses next cycle, mem_flush=1, stall=0, state stays IDLE.
  - access & ~bad: stall=1, mem_flush=1. On the edge, register the bus outputs, mem_req<=1, clear the counter, go to WAIT.
- WAIT:
  - stall=1 and mem_flush=1 (combinational).
  - mem_ack=1: mem_req<=0. For reads, load_data<=aligned mem_rdata. Go to DONE.
  - No ack and counter==TIMEOUT-1: mem_req<=0, load_data<=0, bus_error pulses one cycle, go to DONE.
  - Otherwise: increment the counter.
  - flush_in is ignored while in WAIT; the bus transaction always completes.
- DONE:
  - stall=0, so the instruction advances into MEM/WB this edge with load_data valid.
  - mem_flush=1 if flush_in was seen during WAIT (sticky flag) or bus_error occurred; else 0.
  - Return to IDLE. Exactly one cycle.
- Latency: aligned access with ack on the Nth cycle of WAIT gives stall for N+1 cycles. Minimum total is 3 cycles (IDLE, WAIT, DONE).
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<{addr[1],1'b0}.
  - word: 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata unchanged.
- Load alignment: shift = mem_rdata >> (8*addr[1:0]). Byte takes shift[7:0]; half takes shift[15:0]. Extend to 32 bits per sign_in.
- mem_req never toggles within a transaction. The next request is issued no earlier than one cycle after DONE.
- mem_ack while in IDLE or DONE is ignored.

Test Plan:
- Word load: addr=0x100, ack after 2 WAIT cycles, rdata=0xDEADBEEF -> mem_be=1111, mem_addr=0x100, stall high 3 cycles, load_data=0xDEADBEEF in DONE, mem_flush=0 in DONE.
- Signed byte load: addr=0x103, sign=1, rdata=0x80FF_0000 -> mem_be=1000, load_data=0xFFFFFF80. Repeat with sign=0 -> load_data=0x00000080.
- Half store: addr=0x206, wdata=0x0000_1234 -> mem_we=1, mem_be=1100, mem_wdata=0x12341234, mem_addr=0x204.
- Misaligned word load: addr=0x101 -> mem_req stays 0, misalign pulses once, mem_flush=1, stall=0.
- Timeout: TIMEOUT=4, no ack -> mem_req drops after 4 WAIT cycles, bus_error pulses, load_data=0, mem_flush=1 in DONE.
- Reset and flush: assert reset in WAIT -> all outputs 0 immediately, state IDLE. Separately, pulse flush_in in WAIT then ack -> mem_flush=1 in DONE.
